// File: rtl/dmem_cache_if.sv
// dmem_cache_if: MEM-stage request/response and backing-memory bus for the data cache
interface dmem_cache_if;
  logic        MemRead_2DM;
  logic        MemWrite_2DM;
  logic [31:0] data_address_2DM;
  logic [31:0] data_write_2DM;
  logic [1:0]  data_write_size_2DM;
  logic [31:0] data_read_fDM;
  logic        STALL;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  modport slave (
    input  MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM,
    input  mem_rdata, mem_ack,
    output data_read_fDM, STALL, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
  modport master (
    output MemRead_2DM, MemWrite_2DM, data_address_2DM, data_write_2DM, data_write_size_2DM,
    output mem_rdata, mem_ack,
    input  data_read_fDM, STALL, mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/dmem_cache.sv
// dmem_cache: direct-mapped write-through no-allocate data cache with pipeline stall
module dmem_cache #(
  parameter int INDEX_BITS = 4
) (
  input  logic        CLK,
  input  logic        RESET,
  dmem_cache_if.slave bus,
  output logic [31:0] rd_hits,
  output logic [31:0] rd_misses
);
  localparam int TAG_BITS = 30 - INDEX_BITS;
  localparam int LINES = 1 << INDEX_BITS;
  typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} state_t;
  state_t state_q, state_d;
  logic [LINES-1:0] valid_q, valid_d;
  logic [31:0] line_q [LINES];
  logic [31:0] line_d [LINES];
  logic [TAG_BITS-1:0] tag_q [LINES];
  logic [TAG_BITS-1:0] tag_d [LINES];
  logic [31:0] rd_hits_q, rd_hits_d, rd_misses_q, rd_misses_d;
  logic mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [31:0] mem_addr_q, mem_addr_d, mem_wdata_q, mem_wdata_d;
  logic [3:0] mem_wmask_q, mem_wmask_d;
  logic [INDEX_BITS-1:0] idx;
  logic [TAG_BITS-1:0] tag;
  logic hit, is_ld, is_st, stall;
  logic [2:0] n;
  logic [31:0] st_wdata, lane, rdata;
  logic [3:0] st_mask;
  // Address decode, hit detection and store lane placement (first data byte at the lowest byte offset)
  always_comb begin
    idx = bus.data_address_2DM[INDEX_BITS+1:2];
    tag = bus.data_address_2DM[31:INDEX_BITS+2];
    is_st = bus.MemWrite_2DM;
    is_ld = bus.MemRead_2DM & ~bus.MemWrite_2DM;
    hit = valid_q[idx] && tag_q[idx] == tag;
    n = bus.data_write_size_2DM == 2'd0 ? 3'd4 : {1'b0, bus.data_write_size_2DM};
    st_wdata = (bus.data_write_2DM << {3'd4 - n, 3'b000}) >> {bus.data_address_2DM[1:0], 3'b000};
    st_mask = ~(4'hF >> n) >> bus.data_address_2DM[1:0];
    lane = {{8{mem_wmask_q[3]}}, {8{mem_wmask_q[2]}}, {8{mem_wmask_q[1]}}, {8{mem_wmask_q[0]}}};
  end
  // Next-state, cache update, memory request and pipeline-facing outputs
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    line_d = line_q;
    tag_d = tag_q;
    rd_hits_d = rd_hits_q;
    rd_misses_d = rd_misses_q;
    mem_req_d = mem_req_q;
    mem_we_d = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    stall = 1'b0;
    rdata = 32'd0;
    case (state_q)
      IDLE: begin
        if (is_st) begin
          stall = 1'b1;
          state_d = WRITE;
          mem_req_d = 1'b1;
          mem_we_d = 1'b1;
          mem_addr_d = {bus.data_address_2DM[31:2], 2'b00};
          mem_wdata_d = st_wdata;
          mem_wmask_d = st_mask;
        end else if (is_ld && hit) begin
          rdata = line_q[idx];
          rd_hits_d = rd_hits_q == '1 ? rd_hits_q : rd_hits_q + 32'd1;
        end else if (is_ld) begin
          stall = 1'b1;
          state_d = FILL;
          rd_misses_d = rd_misses_q == '1 ? rd_misses_q : rd_misses_q + 32'd1;
          mem_req_d = 1'b1;
          mem_we_d = 1'b0;
          mem_addr_d = {bus.data_address_2DM[31:2], 2'b00};
          mem_wdata_d = 32'd0;
          mem_wmask_d = 4'hF;
        end
      end
      FILL: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          line_d[idx] = bus.mem_rdata;
          valid_d[idx] = 1'b1;
          tag_d[idx] = tag;
          mem_req_d = 1'b0;
          state_d = DONE;
        end
      end
      WRITE: begin
        stall = 1'b1;
        if (bus.mem_ack) begin
          line_d[idx] = hit ? (line_q[idx] & ~lane) | (mem_wdata_q & lane) : line_q[idx];
          mem_req_d = 1'b0;
          state_d = DONE;
        end
      end
      default: begin
        rdata = is_ld ? line_q[idx] : 32'd0;
        state_d = IDLE;
      end
    endcase
  end
  // Control state, valid bits, counters and registered memory request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= IDLE;
      valid_q <= '0;
      rd_hits_q <= 32'd0;
      rd_misses_q <= 32'd0;
      mem_req_q <= 1'b0;
      mem_we_q <= 1'b0;
      mem_addr_q <= 32'd0;
      mem_wdata_q <= 32'd0;
      mem_wmask_q <= 4'd0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      rd_hits_q <= rd_hits_d;
      rd_misses_q <= rd_misses_d;
      mem_req_q <= mem_req_d;
      mem_we_q <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  end
  // Line data and tags are qualified by valid bits, so they need no reset
  always_ff @(posedge CLK) begin
    line_q <= line_d;
    tag_q <= tag_d;
  end
  assign bus.STALL = ~RESET & stall;
  assign bus.data_read_fDM = RESET ? 32'd0 : rdata;
  assign bus.mem_req = mem_req_q;
  assign bus.mem_we = mem_we_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign rd_hits = rd_hits_q;
  assign rd_misses = rd_misses_q;
endmodule
